io_sequencer: RTL
=================

IO_SEQUENCER -- requirements
Module: io_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of stable cycles Enter must hold before its level is accepted.
REQ-002 The block SHALL have parameter OUT_HOLD_CYCLES, default 8, the number of stall cycles inserted per OUT request.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have ports Input, Output, Halt, input, 1 bit each, CPU requests for the IN, OUT and HALT instructions.
REQ-006 The block SHALL have port Enter, input, 1 bit, the user key, active-high and asynchronous to clk.
REQ-007 The block SHALL have port sw, input, 10 bits, the switch value sampled on IN.
REQ-008 The block SHALL have port output_num, input, 32 bits, the OUT operand.
REQ-009 The block SHALL have port stall, output, 1 bit, which freezes the CPU while high.
REQ-010 The block SHALL have port Input_Data, output, 32 bits, the latched IN value.
REQ-011 The block SHALL have port in_valid, output, 1 bit, a one-cycle strobe marking Input_Data valid.
REQ-012 The block SHALL have port disp_mode, output, 3 bits, the display selector: 0 IDLE, 1 WAIT_IN, 2 SHOW_IN, 3 SHOW_OUT, 4 HALT.
REQ-013 The block SHALL have port disp_value, output, 32 bits, the number to display.
REQ-014 The block SHALL have port halted, output, 1 bit, the sticky halt flag.

Function
REQ-015 Enter SHALL pass through a 2-flop synchronizer; a press SHALL be the rising edge of the conditioned level.
REQ-016 The FSM SHALL have exactly these states: IDLE, WAIT_IN, OUT_HOLD, DONE, HALTED.
REQ-017 Request priority in IDLE SHALL be Halt > Input > Output; when Input and Output are both high, Input SHALL be served.
REQ-018 In IDLE, stall SHALL be high combinationally in any cycle where Input or Output is high.
REQ-019 IDLE with Input high SHALL transition to WAIT_IN.
REQ-020 IDLE with Output high SHALL latch output_num into disp_value, load a counter with OUT_HOLD_CYCLES-1, and transition to OUT_HOLD.
REQ-021 In WAIT_IN, stall SHALL be 1, disp_mode SHALL be 1, and disp_value SHALL equal {22'b0,sw} live.
REQ-022 A press in WAIT_IN SHALL latch {22'b0,sw} into Input_Data and disp_value and transition to DONE.
REQ-023 A press in any state other than WAIT_IN SHALL be ignored; Enter already held on entry to WAIT_IN SHALL NOT count as a press.
REQ-024 In OUT_HOLD, stall SHALL be 1 and disp_mode SHALL be 3; the FSM SHALL transition to DONE when the counter reaches 0; OUT_HOLD_CYCLES=1 SHALL give exactly one stall cycle.
REQ-025 DONE SHALL last exactly one cycle with stall 0, then return to IDLE.
REQ-026 in_valid SHALL be 1 in DONE only when DONE was entered from WAIT_IN.
REQ-027 A request still high in IDLE after DONE SHALL be treated as a new request.
REQ-028 disp_mode SHALL be 2 after an IN completes and 3 after an OUT completes, and SHALL hold until the next request.
REQ-029 Halt SHALL take priority from any state, including mid-WAIT_IN and mid-OUT_HOLD, and SHALL move the FSM to HALTED on the next edge.
REQ-030 In HALTED, stall, halted and disp_mode=4 SHALL hold until reset, and all requests SHALL be ignored.
REQ-031 Input_Data SHALL change only in the WAIT_IN-to-DONE transition.

Reset
REQ-032 When reset is high, the block SHALL immediately set state=IDLE, stall=0, in_valid=0, halted=0, disp_mode=0, disp_value=0, Input_Data=0, the counters to 0 and the synchronizer flops to 0.
REQ-033 Reset asserted mid-operation SHALL abort any pending IN or OUT without asserting in_valid.

Configuration
REQ-034 With IO_DEBOUNCE_EN defined, the synchronized Enter level SHALL update only after DEBOUNCE_CYCLES consecutive equal samples, so glitches shorter than that produce no press.
REQ-035 Without IO_DEBOUNCE_EN, the synchronized level SHALL be used directly, with press latency of 2 cycles plus edge detect, and no debounce counter SHALL be built.

Verification
REQ-036 With sw=10'h2A5 and Input=1, holding Enter 0 for 50 cycles SHALL give stall=1 and disp_mode=1 throughout; an Enter press SHALL give Input_Data=677, one in_valid cycle, then stall=0.
REQ-037 With Output=1, output_num=1234 and OUT_HOLD_CYCLES=8, stall SHALL be high for exactly 8 cycles, then DONE, with disp_mode=3 and disp_value=1234.
REQ-038 With Input and Output both high, the IN SHALL be served first, and the OUT SHALL start in the IDLE cycle following DONE.
REQ-039 Halt asserted in the 3rd cycle of WAIT_IN SHALL give HALTED with in_valid never asserted, and pulsing Enter SHALL have no effect; reset SHALL then return all outputs to zero.
REQ-040 With IO_DEBOUNCE_EN, a 5-cycle Enter glitch in WAIT_IN SHALL produce no press, and a 20-cycle hold SHALL produce exactly one press.
REQ-041 Enter held high before Input rises SHALL produce no press until Enter is released and pressed again.

Source files
------------

// File: rtl/io_sequencer_if.sv
// CPU-side request/response bundle for io_sequencer: IN/OUT/HALT requests,
// user key and switches in; stall, latched input and display selection out.
interface io_sequencer_if;
  logic        Input;
  logic        Output;
  logic        Halt;
  logic        Enter;
  logic [9:0]  sw;
  logic [31:0] output_num;
  logic        stall;
  logic [31:0] Input_Data;
  logic        in_valid;
  logic [2:0]  disp_mode;
  logic [31:0] disp_value;
  logic        halted;

  modport master (
    output Input, Output, Halt, Enter, sw, output_num,
    input  stall, Input_Data, in_valid, disp_mode, disp_value, halted
  );

  modport slave (
    input  Input, Output, Halt, Enter, sw, output_num,
    output stall, Input_Data, in_valid, disp_mode, disp_value, halted
  );
endinterface

// File: rtl/io_sequencer.sv
// IN/OUT/HALT sequencer that stalls the CPU while waiting on the Enter key or an OUT hold.
// Define IO_DEBOUNCE_EN to add a DEBOUNCE_CYCLES stability filter on the synchronized Enter level.
module io_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int OUT_HOLD_CYCLES = 8
) (
  input  logic          clk,
  input  logic          reset,
  io_sequencer_if.slave io
);

  // One counter width covers both the OUT hold and the debounce run length.
  localparam int MAX_COUNT = (OUT_HOLD_CYCLES > DEBOUNCE_CYCLES) ? OUT_HOLD_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W     = $clog2(MAX_COUNT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IN,
    S_OUT_HOLD,
    S_DONE,
    S_HALTED
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [31:0]      disp_value_q, disp_value_d;
  logic [31:0]      in_data_q, in_data_d;
  logic [2:0]       res_mode_q, res_mode_d;
  logic             from_in_q, from_in_d;

  logic sync1_q, sync2_q, level_prev_q;
  logic level, press;

  logic        stall_c, in_valid_c, halted_c;
  logic [2:0]  disp_mode_c;
  logic [31:0] disp_value_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync1_q      <= io.Enter;
      sync2_q      <= sync1_q;
      level_prev_q <= level;
    end
  end

`ifdef IO_DEBOUNCE_EN
  logic             db_level_q;
  logic [CNT_W-1:0] db_cnt_q;

  // The accepted level flips only once the synchronized input has disagreed with it
  // for DEBOUNCE_CYCLES consecutive samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
    end else if (sync2_q == db_level_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_level_q <= sync2_q;
      db_cnt_q   <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + CNT_W'(1);
    end
  end

  assign level = db_level_q;
`else
  assign level = sync2_q;
`endif

  // Edge-based press: a key already held when WAIT_IN is entered never produces one.
  assign press = level & ~level_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_cnt_q   <= '0;
      disp_value_q <= '0;
      in_data_q    <= '0;
      res_mode_q   <= '0;
      from_in_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      disp_value_q <= disp_value_d;
      in_data_q    <= in_data_d;
      res_mode_q   <= res_mode_d;
      from_in_q    <= from_in_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    disp_value_d = disp_value_q;
    in_data_d    = in_data_q;
    res_mode_d   = res_mode_q;
    from_in_d    = from_in_q;
    stall_c      = 1'b0;
    in_valid_c   = 1'b0;
    halted_c     = 1'b0;
    disp_mode_c  = res_mode_q;
    disp_value_c = disp_value_q;

    unique case (state_q)
      S_IDLE: begin
        stall_c = io.Input | io.Output;
        if (io.Halt) begin
          state_d = S_HALTED;
        end else if (io.Input) begin
          state_d = S_WAIT_IN;
        end else if (io.Output) begin
          disp_value_d = io.output_num;
          hold_cnt_d   = CNT_W'(OUT_HOLD_CYCLES - 1);
          res_mode_d   = 3'd3;
          state_d      = S_OUT_HOLD;
        end
      end
      S_WAIT_IN: begin
        stall_c      = 1'b1;
        disp_mode_c  = 3'd1;
        disp_value_c = {22'b0, io.sw};
        if (io.Halt) begin
          state_d = S_HALTED;
        end else if (press) begin
          in_data_d    = {22'b0, io.sw};
          disp_value_d = {22'b0, io.sw};
          res_mode_d   = 3'd2;
          from_in_d    = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_OUT_HOLD: begin
        stall_c     = 1'b1;
        disp_mode_c = 3'd3;
        if (io.Halt) begin
          state_d = S_HALTED;
        end else if (hold_cnt_q == '0) begin
          from_in_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        in_valid_c = from_in_q;
        state_d    = io.Halt ? S_HALTED : S_IDLE;
      end
      S_HALTED: begin
        stall_c     = 1'b1;
        halted_c    = 1'b1;
        disp_mode_c = 3'd4;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The IDLE stall follows the request lines combinationally, so mask it while in reset.
  assign io.stall      = stall_c & ~reset;
  assign io.in_valid   = in_valid_c;
  assign io.halted     = halted_c;
  assign io.disp_mode  = disp_mode_c;
  assign io.disp_value = disp_value_c;
  assign io.Input_Data = in_data_q;

endmodule
